// File: rtl/nonce_range_scheduler.sv
// nonce_range_scheduler
// Schedules one mining job across NUM_CORES replicated hashing cores. The job's
// inclusive nonce range is cut into equal per-core slices (the last core takes
// the remainder). Each core is started with a one-cycle core_reset pulse. The
// block follows each core's progress by counting hash_clk cycles, restarts a
// core just past any golden nonce it reports, and queues hits in a small
// result FIFO. job_done pulses once every core is exhausted and every captured
// hit has been handed to the FIFO.
//
// Ports
//   hash_clk, reset_n         clock; synchronous active-low reset
//   job_valid/job_ready       job handshake (ready only while idle)
//   job_midstate, job_data    work broadcast to all cores
//   job_nonce_min/max         inclusive nonce range of the job
//   abort                     drop the running job (FIFO contents are kept)
//   core_midstate/work_data   registered broadcast to the cores
//   core_nonce_min            per-core start nonce, core i in [32i+31:32i]
//   core_reset                per-core start/restart pulse
//   core_new_golden/nonce     per-core golden nonce report
//   res_valid/ready/nonce/core  result FIFO head
//   job_done                  one-cycle pulse on normal completion
//   res_overflow              sticky, set when a hit is dropped on a full FIFO
module nonce_range_scheduler #(
  parameter int NUM_CORES        = 4,
  parameter int CYCLES_PER_NONCE = 32,
  parameter int DRAIN_NONCES     = 3,
  parameter int RES_DEPTH        = 4
) (
  input  logic                      hash_clk,
  input  logic                      reset_n,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [255:0]              job_midstate,
  input  logic [95:0]               job_data,
  input  logic [31:0]               job_nonce_min,
  input  logic [31:0]               job_nonce_max,
  input  logic                      abort,
  output logic [255:0]              core_midstate,
  output logic [95:0]               core_work_data,
  output logic [32*NUM_CORES-1:0]   core_nonce_min,
  output logic [NUM_CORES-1:0]      core_reset,
  input  logic [NUM_CORES-1:0]      core_new_golden,
  input  logic [32*NUM_CORES-1:0]   core_golden_nonce,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [31:0]               res_nonce,
  output logic [2:0]                res_core,
  output logic                      job_done,
  output logic                      res_overflow
);

  localparam int LOG2N = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 0;
  localparam int PH_W  = (CYCLES_PER_NONCE > 1) ? $clog2(CYCLES_PER_NONCE) : 1;
  localparam int AW    = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW    = $clog2(RES_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_next;

  logic [255:0]         lat_midstate;
  logic [95:0]          lat_data;
  logic [31:0]          lat_min, lat_max;

  logic [NUM_CORES-1:0] core_active, pend_valid, hit_ok, ld_mask;
  logic [31:0]          slice_min  [NUM_CORES];
  logic [31:0]          slice_max  [NUM_CORES];
  logic [31:0]          pend_nonce [NUM_CORES];
  logic [33:0]          pos        [NUM_CORES];
  logic [PH_W-1:0]      phase      [NUM_CORES];
  logic [31:0]          golden     [NUM_CORES];
  logic [31:0]          ld_min     [NUM_CORES];
  logic [31:0]          ld_max     [NUM_CORES];
  logic [32:0]          slice;

  logic                 abort_now, finish_now;
  logic                 drain_valid, push, pop, push_ok, fifo_full;
  logic [2:0]           drain_idx;
  logic [31:0]          drain_nonce;

  logic [34:0]          fifo_mem [RES_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_count;

  assign job_ready = (state == IDLE);

  // State register.
  always_ff @(posedge hash_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state. Completion waits until pending hits have also been drained so
  // that no result can still be in flight when job_done pulses.
  always_comb begin
    state_next = state;
    abort_now  = 1'b0;
    finish_now = 1'b0;
    case (state)
      IDLE: if (job_valid) state_next = LOAD;
      LOAD: begin
        if (abort) begin
          abort_now  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          abort_now  = 1'b1;
          state_next = IDLE;
        end else if (core_active == '0 && pend_valid == '0) begin
          finish_now = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slice split. The span needs 33 bits for a full 2^32 range. Truncating the
  // per-core bounds to 32 bits is exact because every bound lies in the range.
  always_comb begin
    slice = ({1'b0, lat_max} - {1'b0, lat_min} + 33'd1) >> LOG2N;
    for (int i = 0; i < NUM_CORES; i++) begin
      ld_min[i] = lat_min + 32'(i) * slice[31:0];
      ld_max[i] = ld_min[i] + slice[31:0] - 32'd1;
    end
    if (slice == '0) begin
      ld_mask   = NUM_CORES'(1);
      ld_max[0] = lat_max;
    end else begin
      ld_mask             = '1;
      ld_max[NUM_CORES-1] = lat_max;
    end
  end

  // Hit qualification and selection of the lowest-index pending hit. A stale
  // core keeps hashing after it is retired, so pulses from inactive cores or
  // outside a core's slice are ignored.
  always_comb begin
    drain_valid = 1'b0;
    drain_idx   = 3'd0;
    drain_nonce = 32'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      golden[i] = core_golden_nonce[32*i +: 32];
      hit_ok[i] = core_new_golden[i] && core_active[i] && !abort_now &&
                  golden[i] >= slice_min[i] && golden[i] <= slice_max[i];
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pend_valid[i]) begin
        drain_valid = 1'b1;
        drain_idx   = 3'(i);
        drain_nonce = pend_nonce[i];
      end
    end
    pop     = res_valid && res_ready;
    push    = drain_valid && !abort_now;
    push_ok = push && (!fifo_full || pop);
  end

  // Job latch, core broadcast, per-core progress tracking and pending hits.
  // A hit below the slice end restarts the core just past the golden nonce.
  // A hit exactly at the slice end retires the core.
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      lat_midstate   <= '0;
      lat_data       <= '0;
      lat_min        <= '0;
      lat_max        <= '0;
      core_midstate  <= '0;
      core_work_data <= '0;
      core_nonce_min <= '0;
      core_reset     <= '0;
      core_active    <= '0;
      pend_valid     <= '0;
      job_done       <= 1'b0;
      res_overflow   <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slice_min[i]  <= '0;
        slice_max[i]  <= '0;
        pend_nonce[i] <= '0;
        pos[i]        <= '0;
        phase[i]      <= '0;
      end
    end else begin
      core_reset <= '0;
      job_done   <= finish_now;
      if (push && !push_ok) res_overflow <= 1'b1;

      if (state == IDLE && job_valid) begin
        lat_midstate <= job_midstate;
        lat_data     <= job_data;
        lat_min      <= job_nonce_min;
        lat_max      <= job_nonce_max;
      end

      if (state == LOAD && !abort_now) begin
        core_midstate  <= lat_midstate;
        core_work_data <= lat_data;
        core_active    <= ld_mask;
        core_reset     <= ld_mask;
        for (int i = 0; i < NUM_CORES; i++) begin
          core_nonce_min[32*i +: 32] <= ld_min[i];
          slice_min[i] <= ld_min[i];
          slice_max[i] <= ld_max[i];
          pos[i]       <= {2'b00, ld_min[i]};
          phase[i]     <= '0;
        end
      end

      if (abort_now) begin
        core_active <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (hit_ok[i]) begin
            if (golden[i] < slice_max[i]) begin
              core_nonce_min[32*i +: 32] <= golden[i] + 32'd1;
              core_reset[i] <= 1'b1;
              pos[i]        <= {2'b00, golden[i]} + 34'd1;
              phase[i]      <= '0;
            end else begin
              core_active[i] <= 1'b0;
            end
          end else if (core_active[i]) begin
            if (phase[i] == PH_W'(CYCLES_PER_NONCE - 1)) begin
              phase[i] <= '0;
              pos[i]   <= pos[i] + 34'd1;
              if (pos[i] + 34'd1 > {2'b00, slice_max[i]} + 34'(DRAIN_NONCES))
                core_active[i] <= 1'b0;
            end else begin
              phase[i] <= phase[i] + PH_W'(1);
            end
          end
        end
      end

      if (abort_now) begin
        pend_valid <= '0;
      end else begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (hit_ok[i]) begin
            pend_valid[i] <= 1'b1;
            pend_nonce[i] <= golden[i];
          end else if (push && drain_idx == 3'(i)) begin
            pend_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(RES_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)     rd_ptr <= (rd_ptr == AW'(RES_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Result FIFO storage. The storage needs no reset because occupancy gates it.
  always_ff @(posedge hash_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {drain_idx, drain_nonce};
  end

  assign fifo_full             = (fifo_count == CW'(RES_DEPTH));
  assign res_valid             = (fifo_count != '0);
  assign {res_core, res_nonce} = fifo_mem[rd_ptr];

endmodule
